// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer: drives the {c,b,a} select and sel_valid of a 3-to-8
// decoder. It steps over the channels enabled in a mask latched at frame start,
// dwelling DWELL_CYCLES on each one and then blanking for BLANK_CYCLES.
// Optional build macro: SCAN_CONTINUOUS_EN repeats frames until stop or rst.
// Ports:
//   clk, rst           clock (rising edge), async active-high reset
//   start, stop        begin a frame (honoured only in IDLE), synchronous abort
//   chan_mask[7:0]     channel enables, bit i = channel i
//   c, b, a            select MSB..LSB
//   sel_valid          high during a dwell
//   busy               high outside IDLE
//   scan_done          one-cycle pulse on the final cycle of a frame
module scan_select_sequencer #(
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] chan_mask,
  output logic       c,
  output logic       b,
  output logic       a,
  output logic       sel_valid,
  output logic       busy,
  output logic       scan_done
);

  localparam int MAX_C =
    (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DW_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BL_LOAD =
    (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;

  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  // a freshly entered DWELL is already the last cycle of its channel
  localparam bit DW_ENDS = !HAS_BLANK && (DWELL_CYCLES == 1);
  // a freshly entered BLANK is already the last cycle of its channel
  localparam bit BL_ENDS = (BLANK_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    BLANK
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    mask_q;
  logic [2:0]    sel;

  function automatic logic [2:0] low_bit(
    input logic [7:0] m
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic any_above(
    input logic [7:0] m,
    input logic [2:0] idx
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] && (i > int'(idx))) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [2:0] next_above(
    input logic [7:0] m,
    input logic [2:0] idx
  );
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(idx))) r = 3'(i);
    end
    return r;
  endfunction

  logic       last;
  logic [2:0] nxt_sel;
  logic       nxt_last;
  logic [2:0] new_sel;
  logic       new_last;
  logic       new_ok;
  logic       cnt_zero;
  logic       cnt_one;
  logic       leave;

  assign last     = !any_above(mask_q, sel);
  assign nxt_sel  = next_above(mask_q, sel);
  assign nxt_last = !any_above(mask_q, nxt_sel);
  assign new_sel  = low_bit(chan_mask);
  assign new_last = !any_above(chan_mask, new_sel);
  assign new_ok   = (chan_mask != 8'h00);
  assign cnt_zero = (cnt == '0);
  assign cnt_one  = (cnt == CW'(1));

  // the current channel's time is used up this cycle
  assign leave = cnt_zero &&
    ((state == BLANK) || ((state == DWELL) && !HAS_BLANK));

  assign {c, b, a} = sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mask_q    <= 8'h00;
      sel       <= 3'd0;
      sel_valid <= 1'b0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if ((state != IDLE) && stop) begin
        // abort keeps the select so the decoder input does not glitch
        state     <= IDLE;
        sel_valid <= 1'b0;
        busy      <= 1'b0;
      end else if (leave) begin
        if (!last) begin
          state     <= DWELL;
          sel       <= nxt_sel;
          cnt       <= DW_LOAD;
          sel_valid <= 1'b1;
          scan_done <= DW_ENDS && nxt_last;
        end else begin
`ifdef SCAN_CONTINUOUS_EN
          mask_q <= chan_mask;
          if (new_ok) begin
            state     <= DWELL;
            sel       <= new_sel;
            cnt       <= DW_LOAD;
            sel_valid <= 1'b1;
            scan_done <= DW_ENDS && new_last;
          end else begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end
`else
          state     <= IDLE;
          sel_valid <= 1'b0;
          busy      <= 1'b0;
`endif
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (start && !stop && new_ok) begin
              state     <= DWELL;
              mask_q    <= chan_mask;
              sel       <= new_sel;
              cnt       <= DW_LOAD;
              sel_valid <= 1'b1;
              busy      <= 1'b1;
              scan_done <= DW_ENDS && new_last;
            end
          end
          DWELL: begin
            if (!cnt_zero) begin
              cnt       <= cnt - CW'(1);
              scan_done <= !HAS_BLANK && last && cnt_one;
            end else begin
              state     <= BLANK;
              cnt       <= BL_LOAD;
              sel_valid <= 1'b0;
              scan_done <= BL_ENDS && last;
            end
          end
          BLANK: begin
            cnt       <= cnt - CW'(1);
            scan_done <= last && cnt_one;
          end
          default: begin
            state     <= IDLE;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scan_select_sequencer.sv
// tb_scan_select_sequencer: directed table, corner sequences and a
// randomized run against a queue-based expected-cycle model.
module tb_scan_select_sequencer;

  localparam int DW = 4;
`ifdef SCAN_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] chan_mask;
  logic       c0, b0, a0, v0, busy0, done0;
  logic       c1, b1, a1, v1, busy1, done1;

  scan_select_sequencer #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(1)
  ) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .chan_mask(chan_mask),
    .c(c0), .b(b0), .a(a0),
    .sel_valid(v0), .busy(busy0), .scan_done(done0)
  );

  scan_select_sequencer #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(0)
  ) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .chan_mask(chan_mask),
    .c(c1), .b(b1), .a(a1),
    .sel_valid(v1), .busy(busy1), .scan_done(done1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       v;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic       st;
    logic       sp;
    logic [7:0] m;
    obs_t       exp;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  obs_t q0[$];
  obs_t q1[$];
  obs_t cur[2];

  function automatic obs_t mk(int s, bit v, bit bz, bit d);
    obs_t o;
    o.sel  = 3'(s);
    o.v    = v;
    o.busy = bz;
    o.done = d;
    return o;
  endfunction

  function automatic obs_t get(int k);
    if (k == 0) return {c0, b0, a0, v0, busy0, done0};
    return {c1, b1, a1, v1, busy1, done1};
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got sel=%0d v=%b busy=%b done=%b want sel=%0d v=%b busy=%b done=%b",
               name, act.sel, act.v, act.busy, act.done,
               exp.sel, exp.v, exp.busy, exp.done);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(bit st, bit sp, logic [7:0] m,
                     int s, bit v, bit bz, bit d);
    vec_t r;
    r.st  = st;
    r.sp  = sp;
    r.m   = m;
    r.exp = mk(s, v, bz, d);
    tbl.push_back(r);
  endtask

  // model: a frame is a list of expected cycles, one per dwell/blank cycle
  task automatic build(input int k, input logic [7:0] m);
    obs_t t[$];
    obs_t e;
    int   bl;
    bl = (k == 0) ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        for (int d = 0; d < DW; d++) t.push_back(mk(i, 1, 1, 0));
        for (int j = 0; j < bl; j++) t.push_back(mk(i, 0, 1, 0));
      end
    end
    e = t.pop_back();
    e.done = 1'b1;
    t.push_back(e);
    if (k == 0) q0 = t;
    else q1 = t;
  endtask

  task automatic pop(input int k, output obs_t o);
    if (k == 0) o = q0.pop_front();
    else o = q1.pop_front();
  endtask

  task automatic mstep(input int k, input logic st, input logic sp,
                       input logic [7:0] m);
    obs_t o;
    int   n;
    o = cur[k];
    n = (k == 0) ? q0.size() : q1.size();
    if (o.busy) begin
      if (sp) begin
        if (k == 0) q0.delete();
        else q1.delete();
        o.v = 0; o.busy = 0; o.done = 0;
      end else if (n > 0) begin
        pop(k, o);
      end else if (CONT && m != 8'h00) begin
        build(k, m);
        pop(k, o);
      end else begin
        o.v = 0; o.busy = 0; o.done = 0;
      end
    end else if (st && !sp && m != 8'h00) begin
      build(k, m);
      pop(k, o);
    end
    cur[k] = o;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    chan_mask = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_u0", get(0), mk(0, 0, 0, 0));
    check("reset_u1", get(1), mk(0, 0, 0, 0));
    rst = 1'b0;

    // start+stop, empty mask, sparse frame, busy start, mid-frame mask change
    add(1, 1, 8'hFF, 0, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 8'hA4, 2, 1, 1, 0);
    add(0, 0, 8'hFF, 2, 1, 1, 0);
    add(0, 0, 8'hFF, 2, 1, 1, 0);
    add(0, 0, 8'hFF, 2, 1, 1, 0);
    add(0, 0, 8'hFF, 2, 0, 1, 0);
    add(0, 0, 8'hFF, 5, 1, 1, 0);
    add(1, 0, 8'hFF, 5, 1, 1, 0);
    add(0, 0, 8'h00, 5, 1, 1, 0);
    add(0, 0, 8'h00, 5, 1, 1, 0);
    add(0, 0, 8'h00, 5, 0, 1, 0);
    add(0, 0, 8'h00, 7, 1, 1, 0);
    add(0, 0, 8'h00, 7, 1, 1, 0);
    add(0, 0, 8'h00, 7, 1, 1, 0);
    add(0, 0, 8'h00, 7, 1, 1, 0);
    add(0, 0, 8'h00, 7, 0, 1, 1);
    add(0, 1, 8'hFF, 7, 0, 0, 0);
    add(1, 0, 8'h20, 5, 1, 1, 0);
    add(0, 1, 8'h20, 5, 0, 0, 0);
    add(0, 0, 8'h20, 5, 0, 0, 0);
    foreach (tbl[i]) begin
      start = tbl[i].st;
      stop = tbl[i].sp;
      chan_mask = tbl[i].m;
      tick();
      check($sformatf("tbl%0d", i), get(0), tbl[i].exp);
    end
    start = 1'b0;
    stop = 1'b0;

    // full frame, mask FF
    chan_mask = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 41; cyc++) begin
      obs_t e;
      if (cyc <= 40)
        e = mk((cyc - 1) / 5, ((cyc - 1) % 5) < 4, 1, cyc == 40);
      else if (CONT)
        e = mk(0, 1, 1, 0);
      else
        e = mk(7, 0, 0, 0);
      check($sformatf("frame_c%0d", cyc), get(0), e);
      if (cyc < 41) tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;

    // stop during channel 1 dwell
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("stop_c7", get(0), mk(1, 1, 1, 0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_c8", get(0), mk(1, 0, 0, 0));
    tick();
    check("stop_c9", get(0), mk(1, 0, 0, 0));

    // stop on the cycle that would raise scan_done
    chan_mask = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("sup_c4", get(0), mk(7, 1, 1, 0));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("sup_c5", get(0), mk(7, 0, 0, 0));

    // no blanking: channels 0 and 7 back to back
    chan_mask = 8'h81;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      check($sformatf("nobl_c%0d", cyc), get(1),
            mk(cyc <= 4 ? 0 : 7, 1, 1, cyc == 8));
      tick();
    end
    if (CONT) begin
      check("nobl_c9", get(1), mk(0, 1, 1, 0));
      repeat (7) tick();
      check("nobl_c16", get(1), mk(7, 1, 1, 1));
    end else begin
      check("nobl_c9", get(1), mk(7, 0, 0, 0));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("nobl_stop", get(1), mk(7, 0, 0, 0));
    tick();

    // async reset in channel 3 dwell
    chan_mask = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("pre_rst", get(0), mk(3, 1, 1, 0));
    #2 rst = 1'b1;
    #1;
    check("async_rst_u0", get(0), mk(0, 0, 0, 0));
    check("async_rst_u1", get(1), mk(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    cur[0] = mk(0, 0, 0, 0);
    cur[1] = mk(0, 0, 0, 0);
    q0.delete();
    q1.delete();

    // randomized run against the model
    for (int n = 0; n < 2000; n++) begin
      start = ($urandom % 6) == 0;
      stop = ($urandom % 50) == 0;
      if (($urandom % 5) == 0)
        chan_mask = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
      @(posedge clk);
      mstep(0, start, stop, chan_mask);
      mstep(1, start, stop, chan_mask);
      @(negedge clk);
      check("rand_u0", get(0), cur[0]);
      check("rand_u1", get(1), cur[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
